spike_packet_injector: RTL
==========================

Name: spike_packet_injector

Overview:
- Transmitter that feeds host-supplied spike packets into one edge input port of the RANC core grid, typically the west port of core (0,0).
- Accepts field-level spike descriptors (dx, dy, axon, tick) from a host/testbench source and assembles them into router packets.
- Buffers the packets and presents them to the core router using the same empty/ren read handshake that routers use between neighbours.
- Sequences one frame at a time: it loads the frame, drains it, waits for core_done, then reports frame completion.

Parameters:
- PACKET_WIDTH, 30, router packet width
- DX_MSB, 29, dx field MSB
- DX_LSB, 21, dx field LSB
- DY_MSB, 20, dy field MSB
- DY_LSB, 12, dy field LSB
- NUM_AXONS, 256, axons per core; axon field width is $clog2(NUM_AXONS)
- NUM_TICKS, 16, tick field width is $clog2(NUM_TICKS)
- DEPTH, 16, packet buffer entries; must be a power of 2 and at least 2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  host descriptor valid
- in_ready  out  1  injector can accept a descriptor
- in_dx  in  DX_MSB-DX_LSB+1  signed hop count in x
- in_dy  in  DY_MSB-DY_LSB+1  signed hop count in y
- in_axon  in  $clog2(NUM_AXONS)  destination axon
- in_tick  in  $clog2(NUM_TICKS)  delivery tick
- frame_end  in  1  pulse marking the end of the current frame
- core_done  in  1  level signal from the destination core
- dout  out  PACKET_WIDTH  head packet, drives the core's west_in
- empty_out  out  1  no packet available, drives the core's empty_in_west
- ren_in  in  1  read strobe from the core's ren_out_west
- busy  out  1  state is not IDLE
- frame_done  out  1  one-cycle completion pulse
- underflow_err  out  1  sticky; set by a read while empty

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE and the buffer is flushed.
  - Outputs after reset: empty_out=1, dout=0, in_ready=1, busy=0, frame_done=0, underflow_err=0.
  - Reset mid-frame discards all buffered packets; no frame_done is generated.
- Packet assembly: dout[DX_MSB:DX_LSB]=in_dx; dout[DY_MSB:DY_LSB]=in_dy; dout[A+T-1:T]=in_axon; dout[T-1:0]=in_tick, where A and T are the axon and tick field widths.
  - Bits between DY_LSB-1 and A+T are zero-filled; with the defaults there are none.
- Write: a descriptor is accepted on a cycle with in_valid && in_ready.
  - in_ready = !full && (state==IDLE || state==FILL).
- Read handshake is first-word-fall-through:
  - dout shows the head entry whenever empty_out=0.
  - ren_in && !empty_out pops the head at the clock edge; the next entry is visible the following cycle.
  - ren_in while empty_out=1 has no effect on the buffer and sets underflow_err until reset.
  - A simultaneous write and read with occupancy between 1 and DEPTH-1 leaves the count unchanged.
  - A write into an empty buffer makes empty_out fall one cycle after acceptance.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits; full = (count==DEPTH).
- State machine:
  - IDLE: an accepted descriptor moves to FILL. frame_end with no descriptor accepted in that cycle is an empty frame: frame_done pulses the next cycle and the state stays IDLE.
  - FILL: frame_end moves to DRAIN. A descriptor accepted in the same cycle as frame_end belongs to the current frame.
  - DRAIN: in_ready=0. Moves to WAIT_DONE on the cycle the buffer becomes empty.
  - WAIT_DONE: when core_done=1, frame_done pulses for one cycle and the state returns to IDLE.
  - frame_end is ignored in DRAIN and WAIT_DONE.
- The core may pop packets during FILL; packets are never held back until frame_end.
- Latency: descriptor accepted to packet visible at dout is 1 cycle.

Optional Feature:
- Macro: SPIKE_INJECTOR_STATS_EN.
- When defined, the block adds two outputs:
  - pkt_count[15:0]: counts pops, saturating at 16'hFFFF.
  - stall_count[15:0]: counts cycles with in_valid && !in_ready && state==FILL, saturating at 16'hFFFF.
  - Both counters clear on rst and on entry to IDLE from WAIT_DONE, so they cover exactly one frame.
- When not defined, neither port nor the counter logic exists.

Decomposition:
- Shared package (spike_pkg):
  - packet field MSB/LSB constants and the axon/tick width functions.
  - state enum: IDLE=2'd0, FILL=2'd1, DRAIN=2'd2, WAIT_DONE=2'd3.
- Sub-module: injector_fifo, a first-word-fall-through buffer with DEPTH and WIDTH parameters and ports w_en, r_en, data_in, data_out, full, empty, count.
- Frame sequencing and packet assembly stay in the top module.

Test Plan:
- Single packet: write dx=1, dy=0, axon=5, tick=2, then pulse frame_end. Expect dout=30'h0020_0052 and empty_out=0 one cycle later. Pulse ren_in; expect empty_out=1 and state WAIT_DONE. Raise core_done; expect exactly one frame_done pulse and busy=0.
- Fill to full: write 16 descriptors with ren_in=0. Expect in_ready=0 after the 16th and a 17th in_valid not accepted. Pop all 16; expect them in order with axon=0..15.
- Simultaneous write and read at count=8 for 20 cycles: count stays 8, data stays ordered across pointer wrap, no underflow_err.
- Read while empty: ren_in=1 at reset-idle state. Expect underflow_err=1, which stays high until rst.
- Empty frame: frame_end in IDLE with in_valid=0. Expect frame_done the next cycle with core_done never asserted.
- Reset mid-DRAIN with 5 entries buffered: assert rst. Expect empty_out=1, state IDLE, no frame_done, in_ready=1 in the cycle after reset.

Source files
------------

// File: rtl/spike_pkg.sv
// Shared spike packet field layout, default sizing and injector state encoding.
package spike_pkg;

  localparam int SPK_PACKET_WIDTH = 30;
  localparam int SPK_DX_MSB       = 29;
  localparam int SPK_DX_LSB       = 21;
  localparam int SPK_DY_MSB       = 20;
  localparam int SPK_DY_LSB       = 12;
  localparam int SPK_NUM_AXONS    = 256;
  localparam int SPK_NUM_TICKS    = 16;
  localparam int SPK_DEPTH        = 16;

  // Width of the axon or tick field for a given number of axons or ticks.
  function automatic int spk_field_width(input int n);
    return $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    DRAIN     = 2'd2,
    WAIT_DONE = 2'd3
  } inj_state_e;

endpackage

// File: rtl/injector_fifo.sv
// First-word-fall-through packet buffer: data_out shows the head whenever the buffer is not empty.
module injector_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_en,
  input  logic                     r_en,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr, do_rd;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign do_wr    = w_en && !full;
  assign do_rd    = r_en && !empty;
  // Forced to zero while empty so the output is deterministic after reset.
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_wr && !do_rd) begin
        count_q <= count_q + 1'b1;
      end else if (do_rd && !do_wr) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_packet_injector.sv
// Assembles host spike descriptors into router packets and feeds them to a core edge port, one frame at a time.
// Optional per-frame statistics outputs are enabled by defining SPIKE_INJECTOR_STATS_EN.
module spike_packet_injector
  import spike_pkg::*;
#(
  parameter int PACKET_WIDTH = SPK_PACKET_WIDTH,
  parameter int DX_MSB       = SPK_DX_MSB,
  parameter int DX_LSB       = SPK_DX_LSB,
  parameter int DY_MSB       = SPK_DY_MSB,
  parameter int DY_LSB       = SPK_DY_LSB,
  parameter int NUM_AXONS    = SPK_NUM_AXONS,
  parameter int NUM_TICKS    = SPK_NUM_TICKS,
  parameter int DEPTH        = SPK_DEPTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DX_MSB-DX_LSB:0]               in_dx,
  input  logic [DY_MSB-DY_LSB:0]               in_dy,
  input  logic [spk_field_width(NUM_AXONS)-1:0] in_axon,
  input  logic [spk_field_width(NUM_TICKS)-1:0] in_tick,
  input  logic                                 frame_end,
  input  logic                                 core_done,
  output logic [PACKET_WIDTH-1:0]              dout,
  output logic                                 empty_out,
  input  logic                                 ren_in,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic                                 underflow_err
`ifdef SPIKE_INJECTOR_STATS_EN
  ,
  output logic [15:0]                          pkt_count,
  output logic [15:0]                          stall_count
`endif
);

  localparam int AXW = spk_field_width(NUM_AXONS);
  localparam int TKW = spk_field_width(NUM_TICKS);
  localparam int CW  = $clog2(DEPTH) + 1;

  inj_state_e              state_q;
  logic                    busy_q, frame_done_q, underflow_q;
  logic [PACKET_WIDTH-1:0] pkt;
  logic                    fifo_full, fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic                    accept, pop, drained;

  assign in_ready      = !fifo_full && (state_q == IDLE || state_q == FILL);
  assign accept        = in_valid && in_ready;
  assign pop           = ren_in && !fifo_empty;
  // No writes occur in DRAIN, so the last pop is the cycle the buffer empties.
  assign drained       = (fifo_count == '0) || (fifo_count == CW'(1) && pop);
  assign empty_out     = fifo_empty;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign underflow_err = underflow_q;

  always_comb begin
    pkt                     = '0;
    pkt[DX_MSB:DX_LSB]      = in_dx;
    pkt[DY_MSB:DY_LSB]      = in_dy;
    pkt[AXW+TKW-1:TKW]      = in_axon;
    pkt[TKW-1:0]            = in_tick;
  end

  injector_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PACKET_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .w_en     (accept),
    .r_en     (ren_in),
    .data_in  (pkt),
    .data_out (dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= frame_end ? DRAIN : FILL;
            busy_q  <= 1'b1;
          end else if (frame_end) begin
            frame_done_q <= 1'b1;
          end
        end
        FILL: begin
          if (frame_end) state_q <= DRAIN;
        end
        DRAIN: begin
          if (drained) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (core_done) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_q <= 1'b0;
    end else if (ren_in && fifo_empty) begin
      underflow_q <= 1'b1;
    end
  end

`ifdef SPIKE_INJECTOR_STATS_EN
  logic [15:0] pkt_count_q, stall_count_q;
  logic        frame_wrap;

  assign frame_wrap  = (state_q == WAIT_DONE) && core_done;
  assign pkt_count   = pkt_count_q;
  assign stall_count = stall_count_q;

  always_ff @(posedge clk) begin
    if (rst || frame_wrap) begin
      pkt_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      if (pop && pkt_count_q != 16'hFFFF) begin
        pkt_count_q <= pkt_count_q + 16'd1;
      end
      if (in_valid && !in_ready && state_q == FILL && stall_count_q != 16'hFFFF) begin
        stall_count_q <= stall_count_q + 16'd1;
      end
    end
  end
`endif

endmodule
